// File: rtl/rkv_wdog_multi.sv
// Multi-channel watchdog core: NCH independent down-counters with per-channel
// interrupt and one sticky reset request. Define WDOG_WINDOW_EN for window checking on kicks.
module rkv_wdog_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 32,
  parameter logic [3:0]  ECO_REV  = 4'hB,
  localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             wdg_clk,
  input  logic             wdg_rst,
  input  logic             load_we,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0] load_val,
  input  logic [NCH-1:0]   kick,
  input  logic [NCH-1:0]   inten,
  input  logic [NCH-1:0]   resen,
`ifdef WDOG_WINDOW_EN
  input  logic [CNT_W-1:0] win_val,
`endif
  output logic [CNT_W-1:0] cnt_rd,
  output logic [NCH-1:0]   wdogint,
  output logic             wdogres,
  output logic [3:0]       ecorevnum
);

  logic [CNT_W-1:0] load_q [NCH];
  logic [CNT_W-1:0] load_d [NCH];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [NCH-1:0]   int_q, int_d;
  logic             res_q, res_d;

  // Per-channel next state: load > kick > disabled > expiry > decrement.
  always_comb begin
    int_d = int_q;
    res_d = res_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      load_d[i] = load_q[i];
      cnt_d[i]  = cnt_q[i];
      if (load_we && (32'(load_ch) == i)) begin
        load_d[i] = load_val;
        cnt_d[i]  = load_val;
        int_d[i]  = 1'b0;
      end else if (kick[i]) begin
        cnt_d[i] = load_q[i];
        int_d[i] = 1'b0;
`ifdef WDOG_WINDOW_EN
        // Refreshing too early is treated as a fault on this channel.
        if (cnt_q[i] > win_val) begin
          if (resen[i]) begin
            res_d = 1'b1;
          end else begin
            int_d[i] = 1'b1;
          end
        end
`endif
      end else if (!inten[i]) begin
        int_d[i] = 1'b0;
      end else if (cnt_q[i] == '0) begin
        cnt_d[i] = load_q[i];
        int_d[i] = 1'b1;
        if (int_q[i] && resen[i]) begin
          res_d = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wdg_clk) begin
    if (wdg_rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        load_q[i] <= '1;
        cnt_q[i]  <= '1;
      end
      int_q <= '0;
      res_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        load_q[i] <= load_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      int_q <= int_d;
      res_q <= res_d;
    end
  end

  // Read mux; out-of-range channel selects read as zero.
  always_comb begin
    cnt_rd = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(load_ch) == i) begin
        cnt_rd = cnt_q[i];
      end
    end
  end

  assign wdogint   = int_q;
  assign wdogres   = res_q;
  assign ecorevnum = ECO_REV;

endmodule

// File: tb/tb_rkv_wdog_multi.sv
// Randomised and directed bench for rkv_wdog_multi against a behavioural model.
module tb_rkv_wdog_multi;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned CH_W  = 2;

  logic             wdg_clk = 1'b0;
  logic             wdg_rst;
  logic             load_we;
  logic [CH_W-1:0]  load_ch;
  logic [CNT_W-1:0] load_val;
  logic [NCH-1:0]   kick, inten, resen;
`ifdef WDOG_WINDOW_EN
  logic [CNT_W-1:0] win_val;
`endif
  logic [CNT_W-1:0] cnt_rd;
  logic [NCH-1:0]   wdogint;
  logic             wdogres;
  logic [3:0]       ecorevnum;

  always #5 wdg_clk = ~wdg_clk;

  rkv_wdog_multi #(.NCH(NCH), .CNT_W(CNT_W), .ECO_REV(4'hB)) dut (
    .wdg_clk(wdg_clk), .wdg_rst(wdg_rst), .load_we(load_we), .load_ch(load_ch),
    .load_val(load_val), .kick(kick), .inten(inten), .resen(resen),
`ifdef WDOG_WINDOW_EN
    .win_val(win_val),
`endif
    .cnt_rd(cnt_rd), .wdogint(wdogint), .wdogres(wdogres), .ecorevnum(ecorevnum)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural model: remaining ticks per channel, reload value, interrupt flags.
  longint m_load [NCH];
  longint m_cnt  [NCH];
  bit     m_int  [NCH];
  bit     m_res;
  bit     viol;
  logic [NCH-1:0]   exp_int;
  logic [CNT_W-1:0] exp_rd;

  always @(posedge wdg_clk) begin
    if (wdg_rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_load[i] = 64'(33'h1_0000_0000 - 1);
        m_cnt[i]  = m_load[i];
        m_int[i]  = 1'b0;
      end
      m_res = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load_we && int'(load_ch) == i) begin
          m_load[i] = longint'(load_val);
          m_cnt[i]  = m_load[i];
          m_int[i]  = 1'b0;
        end else if (kick[i]) begin
          viol = 1'b0;
`ifdef WDOG_WINDOW_EN
          viol = m_cnt[i] > longint'(win_val);
`endif
          if (viol && resen[i]) m_res = 1'b1;
          m_int[i] = viol && !resen[i];
          m_cnt[i] = m_load[i];
        end else if (!inten[i]) begin
          m_int[i] = 1'b0;
        end else if (m_cnt[i] == 0) begin
          if (m_int[i] && resen[i]) m_res = 1'b1;
          m_int[i] = 1'b1;
          m_cnt[i] = m_load[i];
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    #2;
    for (int i = 0; i < NCH; i++) exp_int[i] = m_int[i];
    exp_rd = (int'(load_ch) < NCH) ? CNT_W'(m_cnt[load_ch]) : '0;
    chk("wdogint", 64'(wdogint), 64'(exp_int));
    chk("wdogres", 64'(wdogres), 64'(m_res));
    chk("cnt_rd", 64'(cnt_rd), 64'(exp_rd));
    chk("ecorevnum", 64'(ecorevnum), 64'h0B);
  end

  task automatic step();
    @(posedge wdg_clk);
    #3;
  endtask

  task automatic do_reset();
    wdg_rst = 1'b1;
    step();
    wdg_rst = 1'b0;
  endtask

  task automatic do_load(input int ch, input int val);
    load_we  = 1'b1;
    load_ch  = CH_W'(ch);
    load_val = CNT_W'(val);
    step();
    load_we  = 1'b0;
  endtask

  int     k;
  longint frozen;

  initial begin
    wdg_rst = 1'b1; load_we = 1'b0; load_ch = '0; load_val = '0;
    kick = '0; inten = '0; resen = '0;
`ifdef WDOG_WINDOW_EN
    win_val = '1;
`endif
    step(); step();
    wdg_rst = 1'b0;
    repeat (5) step();
    chk("idle_int", 64'(wdogint), 64'h0);
    chk("idle_res", 64'(wdogres), 64'h0);
    chk("idle_eco", 64'(ecorevnum), 64'hB);
    chk("idle_cnt", 64'(cnt_rd), 64'hFFFF_FFFF);

    // ch0: interrupt after L+1 edges, reset after 2L+2 edges
    inten = 4'b0001; resen = 4'b0001;
    do_load(0, 10);
    k = 0;
    while (!wdogint[0] && k < 40) begin step(); k++; end
    chk("ch0_int_lat", 64'(k), 64'd11);
    while (!wdogres && k < 60) begin step(); k++; end
    chk("ch0_res_lat", 64'(k), 64'd22);
    kick = 4'b0001; inten = '0;
    step();
    kick = '0;
    repeat (5) step();
    chk("res_sticky", 64'(wdogres), 64'h1);
    // reset wins over a simultaneous load
    wdg_rst = 1'b1; load_we = 1'b1; load_ch = '0; load_val = 7;
    step();
    wdg_rst = 1'b0; load_we = 1'b0;
    chk("rst_cnt", 64'(cnt_rd), 64'hFFFF_FFFF);
    chk("rst_res", 64'(wdogres), 64'h0);

    // ch1: regular kicks keep it alive
    inten = 4'b0010; resen = 4'b0010;
    do_load(1, 5);
    for (int c = 0; c < 50; c++) begin
      kick[1] = (c % 4 == 3);
      step();
      chk("ch1_cnt_pos", 64'(cnt_rd >= 1), 64'h1);
      chk("ch1_int", 64'(wdogint[1]), 64'h0);
    end
    kick = '0;
    chk("ch1_res", 64'(wdogres), 64'h0);

    // ch2: kick exactly on the expiry edge, then load 0
    inten = 4'b0100; resen = 4'b0100;
    do_load(2, 3);
    for (int r = 0; r < 3; r++) begin
      repeat (3) step();
      kick[2] = 1'b1;
      step();
      kick[2] = 1'b0;
      chk("ch2_kick_int", 64'(wdogint[2]), 64'h0);
      chk("ch2_kick_cnt", 64'(cnt_rd), 64'd3);
    end
    do_load(2, 0);
    step();
    chk("ch2_l0_int", 64'(wdogint[2]), 64'h1);
    chk("ch2_l0_res1", 64'(wdogres), 64'h0);
    step();
    chk("ch2_l0_res2", 64'(wdogres), 64'h1);
    inten = '0; resen = '0;
    do_reset();

    // ch3: resen off, interrupt persists, inten drop freezes the counter
    inten = 4'b1000;
    do_load(3, 8);
    k = 0;
    while (!wdogint[3] && k < 40) begin step(); k++; end
    chk("ch3_int_lat", 64'(k), 64'd9);
    repeat (31) step();
    chk("ch3_int_hold", 64'(wdogint[3]), 64'h1);
    chk("ch3_res", 64'(wdogres), 64'h0);
    inten = '0;
    step();
    chk("ch3_int_drop", 64'(wdogint[3]), 64'h0);
    frozen = m_cnt[3];
    repeat (3) step();
    chk("ch3_frozen", 64'(cnt_rd), 64'(frozen));

`ifdef WDOG_WINDOW_EN
    do_reset();
    win_val = 5; inten = 4'b0001; resen = 4'b0001;
    do_load(0, 20);
    repeat (8) step();
    chk("win_cnt12", 64'(cnt_rd), 64'd12);
    kick[0] = 1'b1;
    step();
    kick[0] = 1'b0;
    chk("win_early_res", 64'(wdogres), 64'h1);
    do_reset();
    do_load(0, 20);
    repeat (16) step();
    chk("win_cnt4", 64'(cnt_rd), 64'd4);
    kick[0] = 1'b1;
    step();
    kick[0] = 1'b0;
    chk("win_ok_res", 64'(wdogres), 64'h0);
`endif

    // random traffic checked every cycle by the model
    do_reset();
    inten = '1;
    for (int n = 0; n < 2000; n++) begin
      wdg_rst  = ($urandom_range(0, 299) == 0);
      load_we  = ($urandom_range(0, 11) == 0);
      load_ch  = CH_W'($urandom);
      load_val = CNT_W'($urandom_range(0, 12));
      for (int b = 0; b < NCH; b++) kick[b] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) inten = NCH'($urandom);
      if ($urandom_range(0, 9) == 0) resen = NCH'($urandom);
`ifdef WDOG_WINDOW_EN
      win_val = CNT_W'($urandom_range(0, 12));
`endif
      step();
    end
    wdg_rst = 1'b0; load_we = 1'b0; kick = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
